// File: rtl/packer_pkg.sv
// packer_pkg: constants and helpers shared by the byte packer and its interface.
// The optional flush feature of byte_packer is controlled by PACKER_FLUSH_EN.
package packer_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_LANES = 16;

    // Lanes 0..cnt hold real bytes when a word closes with the lane counter at cnt.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned cnt);
        logic [MAX_LANES:0] mask;
        mask = ((MAX_LANES+1)'(1) << (cnt + 1)) - (MAX_LANES+1)'(1);
        return mask[MAX_LANES-1:0];
    endfunction

endpackage

// File: rtl/byte_packer_if.sv
// byte_packer_if: byte-wide input stream and word-wide output stream of the packer.
// in_last and out_keep exist only when PACKER_FLUSH_EN is defined.
interface byte_packer_if #(
    parameter int LANES = 4
);
    import packer_pkg::*;

    logic [BYTE_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [BYTE_W*LANES-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

`ifdef PACKER_FLUSH_EN
    logic                    in_last;
    logic [LANES-1:0]        out_keep;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_valid
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
`endif

endinterface

// File: rtl/byte_packer.sv
// byte_packer: packs LANES consecutive bytes little-endian into one registered word.
// Defining PACKER_FLUSH_EN adds in_last (early word close) and the out_keep lane mask.
module byte_packer
    import packer_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    byte_packer_if.slave  bus
);

    localparam int                CNT_W    = $clog2(LANES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [LANES-2:0][BYTE_W-1:0]    asm_q, asm_d;
    logic [LANES-1:0][BYTE_W-1:0]    word;
    logic [BYTE_W*LANES-1:0]         out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            accept;
    logic                            consume;
    logic                            closing;

`ifdef PACKER_FLUSH_EN
    logic [LANES-1:0]                out_keep_q, out_keep_d;
    logic [MAX_LANES-1:0]            mask_full;

    assign mask_full = keep_mask(32'(cnt_q));
    assign closing   = accept && ((cnt_q == LAST_CNT) || bus.in_last);
    assign bus.out_keep = out_keep_q;
`else
    assign closing   = accept && (cnt_q == LAST_CNT);
`endif

    // A pending word only blocks input when downstream is not taking it this cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_q && bus.out_ready;

    // Lanes above cnt in asm_q are always zero, so the closing word needs no extra masking.
    always_comb begin
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef PACKER_FLUSH_EN
        out_keep_d  = out_keep_q;
`endif
        word = {{BYTE_W{1'b0}}, asm_q};
        for (int k = 0; k < LANES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word[k] = bus.in_data;
            end
        end

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (closing) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            asm_d       = '0;
`ifdef PACKER_FLUSH_EN
            out_keep_d  = mask_full[LANES-1:0];
`endif
        end else if (accept) begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    asm_d[k] = bus.in_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef PACKER_FLUSH_EN
            out_keep_q  <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef PACKER_FLUSH_EN
            out_keep_q  <= out_keep_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed and randomized checks of byte_packer against a queue-based word model.
// Flush scenarios (in_last/out_keep) are compiled in when PACKER_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_byte_packer;
    import packer_pkg::*;

    localparam int LANES  = 4;
    localparam int WORD_W = BYTE_W * LANES;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  keep;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [BYTE_W-1:0] cur_q[$];
    word_t             exp_q[$];

    byte_packer_if #(.LANES(LANES)) bus();

    byte_packer #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [BYTE_W-1:0] data, input logic ready);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    // Reference model: collect accepted bytes, emit a word when LANES are gathered or in_last arrives.
    always @(negedge clk) begin : model
        logic   model_valid;
        logic   model_in_ready;
        logic   close_now;
        word_t  w;
        if (!rst_n) begin
            cur_q.delete();
            exp_q.delete();
        end else begin
            model_valid    = (exp_q.size() != 0);
            model_in_ready = !model_valid || bus.out_ready;
            checkOutput("mon_out_valid", 64'(bus.out_valid), 64'(model_valid));
            checkOutput("mon_in_ready", 64'(bus.in_ready), 64'(model_in_ready));
            if (model_valid) begin
                checkOutput("mon_out_data", 64'(bus.out_data), 64'(exp_q[0].data));
`ifdef PACKER_FLUSH_EN
                checkOutput("mon_out_keep", 64'(bus.out_keep), 64'(exp_q[0].keep));
`endif
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && model_in_ready) begin
                cur_q.push_back(bus.in_data);
                close_now = (cur_q.size() == LANES);
`ifdef PACKER_FLUSH_EN
                close_now = close_now || bus.in_last;
`endif
                if (close_now) begin
                    w = '0;
                    for (int i = 0; i < cur_q.size(); i++) begin
                        w.data[BYTE_W*i +: BYTE_W] = cur_q[i];
                    end
                    w.keep = LANES'((1 << cur_q.size()) - 1);
                    exp_q.push_back(w);
                    cur_q.delete();
                end
            end
        end
    end

    initial begin
        logic [WORD_W-1:0] exp_word;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.in_last   = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
`ifdef PACKER_FLUSH_EN
        checkOutput("rst_out_keep", 64'(bus.out_keep), 64'd0);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1);

        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b1);
        checkOutput("b2b_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("b2b_data", 64'(bus.out_data), 64'h44332211);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("b2b_valid_drop", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 12; i++) begin
            checkOutput("stream_in_ready", 64'(bus.in_ready), 64'd1);
            applyStimulus(1'b1, 8'(i), 1'b1);
            checkOutput("stream_valid", 64'(bus.out_valid), 64'(i % 4 == 3));
            if (i % 4 == 3) begin
                exp_word = '0;
                for (int k = 0; k < 4; k++) begin
                    exp_word[8*k +: 8] = 8'(i - 3 + k);
                end
                checkOutput("stream_data", 64'(bus.out_data), 64'(exp_word));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hD0, 1'b0);
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stall_data", 64'(bus.out_data), 64'hC3C2C1C0);
        end
        applyStimulus(1'b1, 8'hD0, 1'b1);
        checkOutput("release_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus(1'b1, 8'hD1, 1'b1);
        applyStimulus(1'b1, 8'hD2, 1'b1);
        applyStimulus(1'b1, 8'hD3, 1'b1);
        checkOutput("release_next_data", 64'(bus.out_data), 64'hD3D2D1D0);
        applyStimulus(1'b0, 8'h00, 1'b1);

        applyStimulus(1'b1, 8'hE0, 1'b1);
        applyStimulus(1'b1, 8'hE1, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b1);
        end
        checkOutput("midrst_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("midrst_data", 64'(bus.out_data), 64'hA4A3A2A1);
        applyStimulus(1'b0, 8'h00, 1'b1);

`ifdef PACKER_FLUSH_EN
        applyStimulus(1'b1, 8'h55, 1'b1);
        bus.in_last = 1'b1;
        applyStimulus(1'b1, 8'h66, 1'b1);
        bus.in_last = 1'b0;
        checkOutput("flush_data", 64'(bus.out_data), 64'h00006655);
        checkOutput("flush_keep", 64'(bus.out_keep), 64'b0011);
        applyStimulus(1'b1, 8'h77, 1'b1);
        applyStimulus(1'b1, 8'h88, 1'b1);
        applyStimulus(1'b1, 8'h99, 1'b1);
        applyStimulus(1'b1, 8'hAA, 1'b1);
        checkOutput("after_flush_data", 64'(bus.out_data), 64'hAA998877);
        checkOutput("after_flush_keep", 64'(bus.out_keep), 64'b1111);
        applyStimulus(1'b0, 8'h00, 1'b1);
`endif

        // Random traffic with occasional mid-stream resets; the model checks every cycle.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(99) != 0);
`ifdef PACKER_FLUSH_EN
            bus.in_last = ($urandom_range(3) == 0);
`endif
            applyStimulus(1'($urandom_range(99) < 75), 8'($urandom), 1'($urandom_range(99) < 65));
        end
        rst_n = 1'b1;
`ifdef PACKER_FLUSH_EN
        bus.in_last = 1'b0;
`endif
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
